// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states, flag bit positions.
package alu_cmd_sequencer_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SL  = 3'b011;
    localparam logic [2:0] OP_SR  = 3'b100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Opcodes above shift-right have no defined operation.
    function automatic logic op_is_illegal(input logic [2:0] op);
        return op > OP_SR;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_cmd_fifo.sv
// Command FIFO: DEPTH entries of WIDTH bits, wrap-bit pointers, combinational head read.
module cmd_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_en   = push_i && !full_o;
    assign rd_en   = pop_i && !empty_o;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives an external logical unit one command at a time and holds each result.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int NBIT  = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [NBIT-1:0] cmd_a,
    input  logic [NBIT-1:0] cmd_b,
    input  logic [2:0]      cmd_op,
    output logic [NBIT-1:0] alu_a,
    output logic [NBIT-1:0] alu_b,
    output logic [2:0]      alu_op,
    input  logic [NBIT-1:0] alu_result,
    input  logic            alu_n,
    input  logic            alu_z,
    input  logic            alu_c,
    input  logic            alu_v,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [NBIT-1:0] res_data,
    output logic [3:0]      res_flags,
    output logic            res_err,
    output logic [3:0]      flags_sticky,
    input  logic            flags_clr
);

    localparam int CW = 2*NBIT + 3;

    state_e          state_q, state_d;
    logic [NBIT-1:0] alu_a_q, alu_b_q;
    logic [2:0]      alu_op_q;
    logic [NBIT-1:0] res_data_q;
    logic [3:0]      res_flags_q;
    logic            res_err_q;
    logic [3:0]      flags_sticky_q;

    logic            fifo_full, fifo_empty, fifo_push, fifo_pop, capture;
    logic [CW-1:0]   fifo_rdata;
    logic [3:0]      alu_flags;

    assign fifo_push = cmd_valid && !fifo_full;

    cmd_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i ({cmd_op, cmd_a, cmd_b}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_N] = alu_n;
        alu_flags[FLAG_Z] = alu_z;
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                capture = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    fifo_pop = !fifo_empty;
                    state_d  = fifo_empty ? ST_IDLE : ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= OP_AND;
            res_data_q     <= '0;
            res_flags_q    <= '0;
            res_err_q      <= 1'b0;
            flags_sticky_q <= '0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) {alu_op_q, alu_a_q, alu_b_q} <= fifo_rdata;
            if (capture) begin
                res_data_q  <= alu_result;
                res_flags_q <= alu_flags;
                res_err_q   <= op_is_illegal(alu_op_q);
            end
            // A clear coinciding with a capture keeps only the fresh flags.
            if (flags_clr)    flags_sticky_q <= capture ? alu_flags : 4'b0000;
            else if (capture) flags_sticky_q <= flags_sticky_q | alu_flags;
        end
    end

    assign cmd_ready    = !fifo_full;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign res_valid    = (state_q == ST_HOLD);
    assign res_data     = res_data_q;
    assign res_flags    = res_flags_q;
    assign res_err      = res_err_q;
    assign flags_sticky = flags_sticky_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomised checks of alu_cmd_sequencer against a bench-side logical unit model.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    localparam int NBIT  = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid, cmd_ready;
    logic [NBIT-1:0] cmd_a, cmd_b;
    logic [2:0]      cmd_op;
    logic [NBIT-1:0] alu_a, alu_b, alu_result;
    logic [2:0]      alu_op;
    logic            alu_n, alu_z, alu_c, alu_v;
    logic            res_valid, res_ready, res_err, flags_clr;
    logic [NBIT-1:0] res_data;
    logic [3:0]      res_flags, flags_sticky, alu_fl, ovr_flags;
    logic            alu_ovr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.NBIT(NBIT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags), .res_err(res_err),
        .flags_sticky(flags_sticky), .flags_clr(flags_clr)
    );

    // External logical unit: {N,Z,C,V, result}; shifts are by one with C = bit shifted out.
    function automatic logic [11:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       c;
        r = '0;
        c = 1'b0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SL:   begin r = {a[6:0], 1'b0}; c = a[7]; end
            OP_SR:   begin r = {1'b0, a[7:1]}; c = a[0]; end
            default: return 12'h000;
        endcase
        return {r[7], (r == 8'h00), c, 1'b0, r};
    endfunction

    always_comb begin
        {alu_fl, alu_result} = alu_model(alu_op, alu_a, alu_b);
        if (alu_ovr) alu_fl = ovr_flags;
    end
    assign {alu_n, alu_z, alu_c, alu_v} = alu_fl;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input logic [7:0] d, input logic [3:0] f, input logic e);
        check({tag, "_valid"}, 16'(res_valid), 16'h1);
        check({tag, "_data"},  16'(res_data),  16'(d));
        check({tag, "_flags"}, 16'(res_flags), 16'(f));
        check({tag, "_err"},   16'(res_err),   16'(e));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, 16'(cmd_ready),    16'h1);
        check({tag, "_res_valid"}, 16'(res_valid),    16'h0);
        check({tag, "_alu_a"},     16'(alu_a),        16'h0);
        check({tag, "_alu_b"},     16'(alu_b),        16'h0);
        check({tag, "_alu_op"},    16'(alu_op),       16'h0);
        check({tag, "_res_data"},  16'(res_data),     16'h0);
        check({tag, "_res_flags"}, 16'(res_flags),    16'h0);
        check({tag, "_res_err"},   16'(res_err),      16'h0);
        check({tag, "_sticky"},    16'(flags_sticky), 16'h0);
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    logic [2:0]  bp_op [5] = '{OP_AND, OP_OR, OP_XOR, OP_SL, OP_SR};
    logic [7:0]  bp_a  [5] = '{8'hA5, 8'h50, 8'h33, 8'h81, 8'h81};
    logic [7:0]  bp_b  [5] = '{8'h0F, 8'h0A, 8'h33, 8'h00, 8'h00};
    logic [7:0]  bp_d  [5] = '{8'h05, 8'h5A, 8'h00, 8'h02, 8'h40};
    logic [3:0]  bp_f  [5] = '{4'b0000, 4'b0000, 4'b0100, 4'b0010, 4'b0010};

    logic [12:0] sb [$];
    logic [12:0] prev_res, exp_res, got_res;
    logic [11:0] m;
    logic        hold_prev;
    int          pushed, got, cyc;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        res_ready = 1'b0; flags_clr = 1'b0; alu_ovr = 1'b0; ovr_flags = '0;
        #2;
        check_reset_state("rst");
        step(); step();

        // Single XOR command; accept on the first edge after reset release.
        rst_n = 1'b1;
        set_cmd(OP_XOR, 8'hF0, 8'h3C);
        check("first_ready", 16'(cmd_ready), 16'h1);
        step();
        cmd_valid = 1'b0;
        check("lat_edge1_valid", 16'(res_valid), 16'h0);
        step();
        check("lat_edge2_valid", 16'(res_valid), 16'h0);
        check("issue_alu_op", 16'(alu_op), 16'(OP_XOR));
        check("issue_alu_a", 16'(alu_a), 16'h00F0);
        step();
        check_res("xor", 8'hCC, 4'b1000, 1'b0);
        check("xor_sticky", 16'(flags_sticky), 16'b1000);
        res_ready = 1'b1;
        step();
        check("xor_done", 16'(res_valid), 16'h0);

        // Backpressure: five accepts fill FIFO plus the held result.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(bp_op[i], bp_a[i], bp_b[i]);
            check("bp_ready_before", 16'(cmd_ready), 16'h1);
            step();
        end
        cmd_valid = 1'b0;
        check("bp_full", 16'(cmd_ready), 16'h0);
        step(); step();
        check_res("bp_held", bp_d[0], bp_f[0], 1'b0);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_res("bp_res", bp_d[i], bp_f[i], 1'b0);
            step();
            check("bp_gap", 16'(res_valid), 16'h0);
            if (i == 0) check("bp_ready_after", 16'(cmd_ready), 16'h1);
            if (i < 4) step();
        end

        // Illegal opcode: ALU default of zero is captured, error raised.
        set_cmd(3'b111, 8'hFF, 8'hFF);
        step();
        cmd_valid = 1'b0;
        step(); step();
        check_res("illegal", 8'h00, 4'b0000, 1'b1);
        step();

        // Sticky flags accumulate, and clear-with-capture keeps only the new flags.
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        check("sticky_cleared", 16'(flags_sticky), 16'h0);
        alu_ovr = 1'b1; ovr_flags = 4'b0001;
        set_cmd(OP_AND, 8'h0F, 8'h0F);
        step(); cmd_valid = 1'b0; step(); step();
        check("sticky_v_flags", 16'(res_flags), 16'b0001);
        check("sticky_v", 16'(flags_sticky), 16'b0001);
        alu_ovr = 1'b0;
        step();
        set_cmd(OP_AND, 8'h0F, 8'hF0);
        step(); cmd_valid = 1'b0; step(); step();
        check("sticky_vz", 16'(flags_sticky), 16'b0101);
        step();
        set_cmd(OP_OR, 8'h80, 8'h00);
        step(); cmd_valid = 1'b0; step();
        check("sticky_before_clr", 16'(flags_sticky), 16'b0101);
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        check("sticky_clr_capture", 16'(flags_sticky), 16'b1000);
        check("sticky_clr_data", 16'(res_data), 16'h0080);
        step();

        // Reset while in ISSUE with two entries still queued.
        res_ready = 1'b0;
        set_cmd(OP_AND, 8'h11, 8'h11); step();
        set_cmd(OP_OR,  8'h22, 8'h00); step();
        set_cmd(OP_XOR, 8'h33, 8'h01); step();
        set_cmd(OP_SL,  8'h44, 8'h00); step();
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        step();
        check("pre_rst_issue", 16'(res_valid), 16'h0);
        check("pre_rst_alu_a", 16'(alu_a), 16'h0022);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_mid");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("post_rst_quiet", 16'(res_valid), 16'h0);
            step();
        end
        set_cmd(OP_SL, 8'h01, 8'h00);
        step();
        cmd_valid = 1'b0;
        check("post_rst_lat1", 16'(res_valid), 16'h0);
        step();
        check("post_rst_lat2", 16'(res_valid), 16'h0);
        step();
        check_res("post_rst", 8'h02, 4'b0000, 1'b0);
        step();

        // Random valid/ready stress against a scoreboard.
        pushed = 0; got = 0; cyc = 0; hold_prev = 1'b0; prev_res = '0;
        while (got < 1000 && cyc < 20000) begin
            cmd_valid = (pushed < 1000) && ($urandom_range(0, 3) != 0);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            res_ready = ($urandom_range(0, 2) != 0);
            got_res   = {res_err, res_flags, res_data};
            if (hold_prev) check("st_stable", 16'({res_valid, got_res}), 16'({1'b1, prev_res}));
            if (!cmd_ready) check("st_full_occ", 16'(sb.size() >= DEPTH), 16'h1);
            if (cmd_valid && cmd_ready) begin
                m = alu_model(cmd_op, cmd_a, cmd_b);
                sb.push_back({op_is_illegal(cmd_op), m});
                pushed++;
            end
            if (res_valid && res_ready) begin
                check("st_sb_nonempty", 16'(sb.size() != 0), 16'h1);
                if (sb.size() != 0) begin
                    exp_res = sb.pop_front();
                    check("st_result", 16'(got_res), 16'(exp_res));
                end
                got++;
            end
            hold_prev = res_valid && !res_ready;
            prev_res  = got_res;
            step();
            cyc++;
        end
        cmd_valid = 1'b0;
        check("st_count", 16'(got), 16'(1000));
        check("st_pushed", 16'(pushed), 16'(1000));
        check("st_sb_drained", 16'(sb.size()), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
